// File: rtl/genetico_pkg.sv
// Shared defaults, chromosome size derivations and loader FSM states for the
// genetic-circuit configuration blocks.
package genetico_pkg;

  localparam int NUM_LES_DEF  = 9;
  localparam int LE_BITS_DEF  = 11;
  localparam int NUM_OUTS_DEF = 1;
  localparam int OUT_BITS_DEF = 4;
  localparam int WORD_W_DEF   = 16;

  function automatic int chromW(input int numLes, input int leBits,
                                input int numOuts, input int outBits);
    return numLes * leBits + numOuts * outBits;
  endfunction

  function automatic int numWords(input int chromBits, input int wordW);
    return (chromBits + wordW - 1) / wordW;
  endfunction

  localparam int CHROM_W_DEF = chromW(NUM_LES_DEF, LE_BITS_DEF, NUM_OUTS_DEF, OUT_BITS_DEF);
  localparam int NWORDS_DEF  = numWords(CHROM_W_DEF, WORD_W_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PEND = 2'd2,
    ST_SWAP = 2'd3
  } state_t;

endpackage

// File: rtl/fenotipo_desempacota.sv
// Splits the active chromosome into per-LE configuration and output selector
// fields; purely combinational.
module fenotipo_desempacota
  import genetico_pkg::*;
#(
  parameter int NUM_LES  = NUM_LES_DEF,
  parameter int LE_BITS  = LE_BITS_DEF,
  parameter int NUM_OUTS = NUM_OUTS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF
) (
  input  logic [NUM_LES*LE_BITS+NUM_OUTS*OUT_BITS-1:0] i_active,
  output logic [NUM_LES*LE_BITS-1:0]                   o_confLes,
  output logic [NUM_OUTS*OUT_BITS-1:0]                 o_confOuts
);

  localparam int LES_W = NUM_LES * LE_BITS;
  localparam int OUTS_W = NUM_OUTS * OUT_BITS;

  assign o_confLes  = i_active[LES_W-1:0];
  assign o_confOuts = i_active[LES_W +: OUTS_W];

endmodule

// File: rtl/fenotipo_carregador.sv
// Double-buffered chromosome loader: words fill a shadow register, and the
// shadow is promoted to the active configuration only while the circuit is idle.
module fenotipo_carregador
  import genetico_pkg::*;
#(
  parameter int NUM_LES  = NUM_LES_DEF,
  parameter int LE_BITS  = LE_BITS_DEF,
  parameter int NUM_OUTS = NUM_OUTS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF,
  parameter int WORD_W   = WORD_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         word_valid,
  input  logic [WORD_W-1:0]            word_data,
  input  logic                         word_last,
  output logic                         word_ready,
  input  logic                         processing,
  input  logic                         abort,
  output logic [NUM_LES*LE_BITS-1:0]   conf_les,
  output logic [NUM_OUTS*OUT_BITS-1:0] conf_outs,
  output logic                         conf_valid,
  output logic                         load_done,
  output logic                         load_err
);

  localparam int CHROM_W = chromW(NUM_LES, LE_BITS, NUM_OUTS, OUT_BITS);
  localparam int NWORDS  = numWords(CHROM_W, WORD_W);
  localparam int CNT_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_wordCnt;
  logic [CHROM_W-1:0] r_shadow;
  logic [CHROM_W-1:0] r_active;
  logic               r_confValid;
  logic               r_loadDone;
  logic               r_loadErr;

  logic w_xfer;
  logic w_lastIdx;

  assign word_ready = !rst && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
  assign w_xfer     = word_valid && word_ready;
  assign w_lastIdx  = (r_wordCnt == CNT_W'(NWORDS - 1));

  // Bits beyond CHROM_W in the final word have no destination and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wordCnt   <= '0;
      r_shadow    <= '0;
      r_active    <= '0;
      r_confValid <= 1'b0;
      r_loadDone  <= 1'b0;
      r_loadErr   <= 1'b0;
    end else begin
      r_loadDone <= 1'b0;
      r_loadErr  <= 1'b0;
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          if (abort && (r_state == ST_LOAD)) begin
            r_state   <= ST_IDLE;
            r_wordCnt <= '0;
            r_shadow  <= '0;
          end else if (w_xfer) begin
            for (int b = 0; b < CHROM_W; b++) begin
              if ((b / WORD_W) == int'(r_wordCnt)) r_shadow[b] <= word_data[b % WORD_W];
            end
            if (w_lastIdx && word_last) begin
              r_state   <= ST_PEND;
              r_wordCnt <= '0;
            end else if (w_lastIdx || word_last) begin
              r_state   <= ST_IDLE;
              r_wordCnt <= '0;
              r_shadow  <= '0;
              r_loadErr <= 1'b1;
            end else begin
              r_state   <= ST_LOAD;
              r_wordCnt <= r_wordCnt + 1'b1;
            end
          end
        end
        // A complete chromosome waits here until the circuit stops evaluating.
        ST_PEND: begin
          if (abort) begin
            r_state  <= ST_IDLE;
            r_shadow <= '0;
          end else if (!processing) begin
            r_state <= ST_SWAP;
          end
        end
        ST_SWAP: begin
          r_active    <= r_shadow;
          r_confValid <= 1'b1;
          r_loadDone  <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign conf_valid = r_confValid;
  assign load_done  = r_loadDone;
  assign load_err   = r_loadErr;

  fenotipo_desempacota #(
    .NUM_LES (NUM_LES),
    .LE_BITS (LE_BITS),
    .NUM_OUTS(NUM_OUTS),
    .OUT_BITS(OUT_BITS)
  ) uDesempacota (
    .i_active  (r_active),
    .o_confLes (conf_les),
    .o_confOuts(conf_outs)
  );

endmodule
